// File: rtl/fp_sqrt_ctrl_pkg.sv
// Shared FPU definitions: IEEE-754 single field positions, canonical results, controller states.
package fp_sqrt_ctrl_pkg;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fp_sqrt_ctrl_classify.sv
// Combinational IEEE-754 single-precision operand classifier, shared by FPU front-ends.
module fp_classify
  import fp_sqrt_ctrl_pkg::*;
(
  input  logic [31:0] i_op,
  output logic        o_is_nan,
  output logic        o_is_snan,
  output logic        o_is_zero,
  output logic        o_is_inf,
  output logic        o_sign
);

  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic        w_exp_max;
  logic        w_mant_nz;

  assign w_exp     = i_op[EXP_MSB:EXP_LSB];
  assign w_mant    = i_op[MANT_MSB:0];
  assign w_exp_max = &w_exp;
  assign w_mant_nz = |w_mant;

  // Denormals report as zero: they are flushed by every consumer.
  assign o_is_nan  = w_exp_max & w_mant_nz;
  assign o_is_snan = o_is_nan & ~w_mant[MANT_MSB];
  assign o_is_zero = ~|w_exp;
  assign o_is_inf  = w_exp_max & ~w_mant_nz;
  assign o_sign    = i_op[SIGN_BIT];

endmodule

// File: rtl/fp_sqrt_ctrl.sv
// Square-root front-end: valid/ready handshake, one-cycle special-case results,
// and a fixed-latency launch/capture sequence around the external iterative core.
module fp_sqrt_ctrl
  import fp_sqrt_ctrl_pkg::*;
#(
  parameter int CORE_LAT = 17  // 1..63, fits the 6-bit counter
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_op,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_res,
  output logic        o_out_invalid,
  output logic        o_out_special,
  output logic        o_core_start,
  output logic [31:0] o_core_op,
  input  logic [31:0] i_core_res
);

  localparam logic [5:0] CNT_LOAD = 6'(CORE_LAT);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_out_res;
  logic        r_out_invalid;
  logic        r_out_special;
  logic        r_core_start;
  logic [31:0] r_core_op;

  logic        w_is_nan, w_is_snan, w_is_zero, w_is_inf, w_sign;
  logic        w_spec_hit;
  logic [31:0] w_spec_res;
  logic        w_spec_inv;

  fp_classify u_classify (
    .i_op      (i_in_op),
    .o_is_nan  (w_is_nan),
    .o_is_snan (w_is_snan),
    .o_is_zero (w_is_zero),
    .o_is_inf  (w_is_inf),
    .o_sign    (w_sign)
  );

  // Priority order matters: NaN beats zero beats negative beats +inf.
  always_comb begin
    w_spec_hit = 1'b1;
    w_spec_res = FP_QNAN;
    w_spec_inv = 1'b0;
    if (w_is_nan) begin
      w_spec_inv = w_is_snan;
    end else if (w_is_zero) begin
      w_spec_res = {w_sign, 31'b0};
    end else if (w_sign) begin
      w_spec_inv = 1'b1;
    end else if (w_is_inf) begin
      w_spec_res = FP_PINF;
    end else begin
      w_spec_hit = 1'b0;
      w_spec_res = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_res     <= '0;
      r_out_invalid <= 1'b0;
      r_out_special <= 1'b0;
      r_core_start  <= 1'b0;
      r_core_op     <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_core_op  <= i_in_op;
            r_in_ready <= 1'b0;
            if (w_spec_hit) begin
              r_out_res     <= w_spec_res;
              r_out_invalid <= w_spec_inv;
              r_out_special <= 1'b1;
              r_out_valid   <= 1'b1;
              r_state       <= HOLD;
            end else begin
              r_cnt        <= CNT_LOAD;
              r_core_start <= 1'b1;
              r_state      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
          // Count of 1 marks the cycle the core result is valid on its port.
          if (r_cnt == 6'd1) begin
            r_out_res     <= i_core_res;
            r_out_invalid <= 1'b0;
            r_out_special <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_out_valid;
  assign o_out_res     = r_out_res;
  assign o_out_invalid = r_out_invalid;
  assign o_out_special = r_out_special;
  assign o_core_start  = r_core_start;
  assign o_core_op     = r_core_op;

endmodule

// File: doc/fp_sqrt_ctrl.md
# fp_sqrt_ctrl

Handshake front-end and special-case handler wrapped around the `fp_sqrt` iterative core.
- Accepts single-precision operands over a valid/ready interface and classifies each one.
- Resolves zero, negative, infinity and NaN inputs locally in one cycle.
- Launches the core only for normal positive operands, then holds the result until the consumer takes it.
- Sits between the FPU operand dispatcher and `fp_sqrt`; one operation is in flight at a time.

## Interface
Parameters:
- `CORE_LAT`, default 17: cycles from the `core_start` cycle to the cycle in which `core_res` is valid and sampled. Range 1..63.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block can accept an operand; equals (state==IDLE).
- `in_op`  in  32  IEEE-754 single operand.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `out_res`  out  32  result.
- `out_invalid`  out  1  invalid-operation flag for this result.
- `out_special`  out  1  result produced by the special-case path, not the core.
- `core_start`  out  1  one-cycle launch pulse to `fp_sqrt.start`.
- `core_op`  out  32  operand to `fp_sqrt.op`; held stable throughout BUSY.
- `core_res`  in  32  `fp_sqrt.res`.

## Operation
- States: IDLE, BUSY, HOLD. Reset state is IDLE.
- IDLE, on `in_valid`=1: register `in_op` into `core_op` and classify it, in priority order:
  1. exp=255 and mant≠0 (NaN): result 0x7FC00000; `out_invalid`=~mant[22] (signalling NaN only); go to HOLD.
  2. exp=0 (zero or denormal, flushed): result {sign,31'b0}; go to HOLD.
  3. sign=1 (negative normal or -inf): result 0x7FC00000, `out_invalid`=1; go to HOLD.
  4. 0x7F800000 (+inf): result 0x7F800000; go to HOLD.
  5. Otherwise: go to BUSY with `core_start`=1 in the first BUSY cycle; load counter with CORE_LAT.
- Special-path results set `out_special`=1. Core results set `out_special`=0 and `out_invalid`=0.
- BUSY:
  - Counter decrements each cycle.
  - At the edge ending the cycle where counter=1, register `core_res` into `out_res` and go to HOLD.
  - `core_start` is low in every BUSY cycle except the first.
- HOLD:
  - `out_valid`=1; `out_res` and flags are stable.
  - On `out_ready`=1, go to IDLE.
  - `out_valid` never drops without `out_ready`.
- No back-to-back overlap: `in_ready` is low in BUSY and HOLD.
- Counter width is 6 bits and never wraps; it is reloaded only on IDLE->BUSY.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_res`=0, `out_invalid`=0, `out_special`=0, `core_start`=0, `core_op`=0, counter=0.
- Accept in cycle T (`in_valid` & `in_ready`):
  - Special path: `out_valid` in cycle T+1, so latency is 1.
  - Core path: `core_start` in cycle T+1; `core_res` sampled at the end of cycle T+CORE_LAT; `out_valid` in cycle T+CORE_LAT+1.
- Minimum accept-to-accept interval: 2 cycles (special path) or CORE_LAT+2 cycles (core path), when `out_ready` is held high.
- `out_ready` asserted while not in HOLD has no effect.
- Reset mid-operation:
  - Returns to IDLE immediately and drops `out_valid`.
  - Any in-flight core result is discarded.
  - The core is reset from the same reset net, inverted at the FPU top.

## Structure
- Shared FPU package holds:
  - `FP_QNAN`=32'h7FC00000 and `FP_PINF`=32'h7F800000.
  - State encoding: IDLE=2'd0, BUSY=2'd1, HOLD=2'd2.
  - Field slicing constants: sign bit 31, exp [30:23], mant [22:0].
- One combinational sub-module, `fp_classify`:
  - Input: 32-bit operand.
  - Outputs: is_nan, is_snan, is_zero, is_inf, sign.
  - It is reusable by the divider and multiplier front-ends.
- `fp_sqrt` is instantiated at the FPU top, not inside this block.

## Test plan
- Normal operand, core stubbed to return 0x40000000 at CORE_LAT=17: `in_op`=0x40800000 (4.0) accepted at T -> `core_start` at T+1, `out_valid` at T+18, `out_res`=0x40000000, `out_invalid`=0, `out_special`=0.
- Negative operand: `in_op`=0xBF800000 -> `out_valid` at T+1, `out_res`=0x7FC00000, `out_invalid`=1, `out_special`=1, no `core_start`.
- Zeros and denormals: `in_op`=0x80000000 -> `out_res`=0x80000000; `in_op`=0x00000001 -> `out_res`=0x00000000; `out_invalid`=0 in both cases.
- Infinity and NaNs:
  - 0x7F800000 -> 0x7F800000, `out_invalid`=0.
  - 0x7F800001 (sNaN) -> 0x7FC00000, `out_invalid`=1.
  - 0x7FC00001 (qNaN) -> 0x7FC00000, `out_invalid`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD -> `out_valid`, `out_res` and flags stable and `in_ready`=0; `out_ready`=1 -> IDLE next cycle and a new op is accepted.
- Reset mid-BUSY: assert `rst`=0 at T+5 of a core op -> outputs at reset values asynchronously; after release, `in_ready`=1 and no stale `out_valid` appears.
